// File: rtl/i2s_tx96.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx96
// Brief    : Stereo 32-bit I2S transmitter, 64 BCK/frame, BCK/LRCK from mclk.
//            Optional macro MUTE_ON_UNDERRUN_EN: an underrun sends silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx96 #(
    parameter int BCK_DIV = 8
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [31:0] pcm_left,
    input  logic [31:0] pcm_right,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        underrun_clr,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data,
    output logic        frame_tick,
    output logic        underrun
);

    localparam int              c_DW       = $clog2(BCK_DIV);
    localparam logic [c_DW-1:0] c_DIV_MAX  = c_DW'(BCK_DIV - 1);
    localparam logic [c_DW-1:0] c_DIV_HALF = c_DW'(BCK_DIV / 2);

    logic [c_DW-1:0] r_div;
    logic [5:0]      r_bit;
    logic            r_bck, r_lrck, r_data, r_tick, r_underrun;
    logic            r_full, r_ready;
    logic [63:0]     r_shift, r_buf, r_last;

    logic [c_DW-1:0] w_div_next;
    logic [5:0]      w_bit_next;
    logic            w_div_wrap, w_load, w_accept, w_ur_src, w_ur_ev, w_full_next;
    logic [63:0]     w_src;

    assign w_div_wrap = (r_div == c_DIV_MAX);
    assign w_div_next = w_div_wrap ? '0 : r_div + 1'b1;
    assign w_bit_next = r_bit + 6'd1;
    assign w_load     = w_div_wrap && (r_bit == 6'd0);
    assign w_accept   = in_valid & r_ready;
    assign w_ur_src   = ~r_full & ~in_valid;
    assign w_ur_ev    = w_load & w_ur_src;

    // Load source: buffered sample first, else bypass the live inputs.
    always_comb begin
        w_src = r_last;
        if (r_full) begin
            w_src = r_buf;
        end else if (in_valid) begin
            w_src = {pcm_left, pcm_right};
        end else begin
`ifdef MUTE_ON_UNDERRUN_EN
            w_src = 64'h0;
`else
            w_src = r_last;
`endif
        end
    end

    // A load always empties the buffer; a bypassed sample never enters it.
    always_comb begin
        w_full_next = r_full;
        if (w_load) begin
            w_full_next = 1'b0;
        end else if (w_accept) begin
            w_full_next = 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_div      <= '0;
            r_bit      <= 6'd0;
            r_bck      <= 1'b0;
            r_lrck     <= 1'b0;
            r_data     <= 1'b0;
            r_tick     <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
            r_ready    <= 1'b0;
            r_shift    <= 64'h0;
            r_buf      <= 64'h0;
            r_last     <= 64'h0;
        end else begin
            r_div   <= w_div_next;
            r_bck   <= (w_div_next >= c_DIV_HALF);
            r_tick  <= w_load;
            r_full  <= w_full_next;
            r_ready <= ~w_full_next;

            if (!w_load && w_accept) begin
                r_buf <= {pcm_left, pcm_right};
            end

            if (w_div_wrap) begin
                r_bit  <= w_bit_next;
                r_lrck <= w_bit_next[5];
                if (w_load) begin
                    r_shift <= w_src;
                    r_data  <= w_src[63];
                end else begin
                    r_shift <= {r_shift[62:0], 1'b0};
                    r_data  <= r_shift[62];
                end
            end

            if (w_load && !w_ur_src) begin
                r_last <= w_src;
            end

            if (w_ur_ev) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign in_ready   = r_ready;
    assign i2s_bck    = r_bck;
    assign i2s_lrck   = r_lrck;
    assign i2s_data   = r_data;
    assign frame_tick = r_tick;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx96.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx96
// Brief    : Scoreboard bench for i2s_tx96; timing derived from edge count,
//            frames rebuilt from the serial stream and compared to a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx96;

    localparam int BCK_DIV = 8;
    localparam int FRAME   = 64 * BCK_DIV;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcm_left = 32'h0;
    logic [31:0] pcm_right = 32'h0;
    logic        in_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        in_ready, i2s_bck, i2s_lrck, i2s_data, frame_tick, underrun;

    i2s_tx96 #(.BCK_DIV(BCK_DIV)) dut (
        .mclk         (mclk),
        .reset        (reset),
        .pcm_left     (pcm_left),
        .pcm_right    (pcm_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .underrun_clr (underrun_clr),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .frame_tick   (frame_tick),
        .underrun     (underrun)
    );

    always #5 mclk = ~mclk;

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state: k = mclk edges since reset released.
    int          k = 0;
    bit          m_inrst = 1'b1;
    bit          m_full = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_ur = 1'b0;
    logic [63:0] m_buf = 64'h0;
    logic [63:0] m_last = 64'h0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge mclk) begin
        logic [63:0] fr;
        bit          ur_set;
        if (reset) begin
            k = 0; m_inrst = 1'b1; m_full = 1'b0; m_ready = 1'b0;
            m_ur = 1'b0; m_buf = 64'h0; m_last = 64'h0;
            exp_q.delete();
        end else begin
            m_inrst = 1'b0;
            k++;
            ur_set = 1'b0;
            if (k % FRAME == BCK_DIV) begin
                if (m_full) begin
                    fr = m_buf; m_full = 1'b0; m_last = fr;
                end else if (in_valid) begin
                    fr = {pcm_left, pcm_right}; m_last = fr;
                end else begin
                    ur_set = 1'b1;
`ifdef MUTE_ON_UNDERRUN_EN
                    fr = 64'h0;
`else
                    fr = m_last;
`endif
                end
                exp_q.push_back(fr);
            end else if (in_valid && m_ready) begin
                m_buf = {pcm_left, pcm_right}; m_full = 1'b1;
            end
            if (ur_set) m_ur = 1'b1;
            else if (underrun_clr) m_ur = 1'b0;
            m_ready = !m_full;
        end
    end

    // Monitor: per-cycle timing checks plus frame reassembly on BCK rises.
    logic [63:0] bits = 64'h0;
    int          nbits = 0;
    logic        prev_bck = 1'b0;

    always @(negedge mclk) begin
        logic [63:0] e;
        chk("bck",   i2s_bck,   ((k % BCK_DIV) >= BCK_DIV / 2));
        chk("lrck",  i2s_lrck,  (((k / BCK_DIV) % 64) >= 32));
        chk("tick",  frame_tick, (k % FRAME == BCK_DIV));
        chk("ready", in_ready,  m_ready);
        chk("underrun", underrun, m_ur);
        if (m_inrst) begin
            chk("data_rst", i2s_data, 1'b0);
            nbits = 0;
        end else begin
            if (k % FRAME == BCK_DIV) nbits = 0;
            if (!prev_bck && i2s_bck) begin
                bits = {bits[62:0], i2s_data};
                nbits++;
                if (nbits == 64) begin
                    if (exp_q.size() == 0) begin
                        chk("frame_q_empty", 64'h1, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", bits, e);
                    end
                    nbits = 0;
                end
            end
        end
        prev_bck = i2s_bck;
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_phase(input int ph);
        int g = 0;
        do begin
            step();
            g++;
        end while ((k % FRAME) != ph && g <= FRAME + 1);
        if ((k % FRAME) != ph) chk("wait_phase_timeout", 64'h1, 64'h0);
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r);
        bit acc;
        int g = 0;
        in_valid = 1'b1; pcm_left = l; pcm_right = r;
        do begin
            acc = in_ready;
            step();
            g++;
        end while (!acc && g < 2 * FRAME);
        if (!acc) chk("send_timeout", 64'h1, 64'h0);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] n;
        bit acc;
        // Reset then idle: timing, underrun of an all-zero frame
        reset = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        wait_phase(300);
        pulse_clr();
        wait_phase(100);

        // Serialisation pattern, then clear once supply has resumed
        send(32'h8000_0001, 32'h7FFF_FFFE);
        wait_phase(20);
        pulse_clr();
        wait_phase(400);

        // Continuous supply of incrementing samples
        n = 32'd1;
        in_valid = 1'b1; pcm_left = n; pcm_right = ~n;
        for (int i = 0; i < 3 * FRAME; i++) begin
            acc = in_ready;
            step();
            if (acc) begin
                n++; pcm_left = n; pcm_right = ~n;
            end
        end
        in_valid = 1'b0;

        // Drain the buffer, then bypass in the load cycle only
        wait_phase(BCK_DIV + 1);
        wait_phase(BCK_DIV - 1);
        in_valid = 1'b1; pcm_left = 32'h1234_5678; pcm_right = 32'h0BAD_F00D;
        step();
        in_valid = 1'b0;

        // Underrun: repeat (or mute) for two frames, clear mid-way, resume
        send(32'hA5A5_A5A5, 32'h5A5A_5A5A);
        wait_phase(BCK_DIV + 1);
        wait_phase(BCK_DIV + 1);
        pulse_clr();
        wait_phase(BCK_DIV + 1);
        send(32'h0F0F_1234, 32'hCAFE_0001);
        wait_phase(200);
        pulse_clr();

        // Randomised traffic
        for (int i = 0; i < 5 * FRAME; i++) begin
            in_valid     = ($urandom_range(0, 99) < 2);
            pcm_left     = $urandom;
            pcm_right    = $urandom;
            underrun_clr = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0; underrun_clr = 1'b0;

        // Mid-frame reset at bit_cnt 20
        send($urandom, $urandom);
        wait_phase(BCK_DIV * 20 + 3);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        send($urandom, $urandom);
        for (int i = 0; i < 2 * FRAME; i++) begin
            in_valid  = ($urandom_range(0, 99) < 3);
            pcm_left  = $urandom;
            pcm_right = $urandom;
            step();
        end
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
